// File: rtl/lrwait_queue_table.sv
// Per-bank LRWait queue table: tracks head/tail waiters per reserved address, injects
// SuccUpdate / failure responses and forwards everything else to the bank.
// Optional LRWAIT_TABLE_FULL_STALL_EN: an LRWait that misses on a full table stalls instead of erroring.
`timescale 1ns/1ps
module lrwait_queue_table #(
  parameter int unsigned NumSlots    = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned MetaWidth   = 16,
  parameter int unsigned MetaIdWidth = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Valid never waits on ready; in_ready_o may depend on the request fields.
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic [3:0]           in_amo_i,
  input  logic [DataWidth-1:0] in_wdata_i,
  input  logic [MetaWidth-1:0] in_meta_i,
  input  logic                 in_lrwait_i,
  output logic                 bank_req_valid_o,
  input  logic                 bank_req_ready_i,
  output logic [AddrWidth-1:0] bank_addr_o,
  output logic [3:0]           bank_amo_o,
  output logic [DataWidth-1:0] bank_wdata_o,
  output logic [MetaWidth-1:0] bank_meta_o,
  input  logic                 bank_resp_valid_i,
  output logic                 bank_resp_ready_o,
  input  logic [DataWidth-1:0] bank_resp_data_i,
  input  logic [MetaWidth-1:0] bank_resp_meta_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_data_o,
  output logic [MetaWidth-1:0] resp_meta_o,
  output logic                 resp_error_o,
  output logic                 resp_lrwait_o
);

  localparam int unsigned IdxWidth  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int unsigned CoreWidth = MetaWidth - MetaIdWidth;
  localparam logic [3:0]  AmoLrWait = 4'hC;
  localparam logic [3:0]  AmoScWait = 4'hD;

  typedef enum logic [2:0] {
    ActPass,
    ActLrHit,
    ActLrAlloc,
    ActLrFull,
    ActWakeHit,
    ActWakeDrop,
    ActScFwd,
    ActScFail
  } action_e;

  logic [NumSlots-1:0]  slot_valid_q;
  logic [AddrWidth-1:0] slot_addr_q [NumSlots];
  logic [MetaWidth-1:0] slot_head_q [NumSlots];
  logic [MetaWidth-1:0] slot_tail_q [NumSlots];

  logic                 inj_valid_q;
  logic [DataWidth-1:0] inj_data_q;
  logic [MetaWidth-1:0] inj_meta_q;
  logic                 inj_error_q;
  logic                 inj_lrwait_q;

  logic                 hit;
  logic [IdxWidth-1:0]  hit_idx;
  logic                 free_any;
  logic [IdxWidth-1:0]  free_idx;
  logic [MetaWidth-1:0] hit_head;
  logic [MetaWidth-1:0] hit_tail;
  logic                 is_head;
  logic                 last_waiter;
  action_e              action;

  logic                 req_ready_raw;
  logic                 fwd;
  logic                 req_act;
  logic                 accept;
  logic [DataWidth-1:0] fwd_wdata;
  logic [MetaWidth-1:0] fwd_meta;
  logic                 inj_set;
  logic [DataWidth-1:0] inj_data_d;
  logic [MetaWidth-1:0] inj_meta_d;
  logic                 inj_error_d;
  logic                 inj_lrwait_d;

  // Address lookup; at most one valid slot can hold a given address.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(NumSlots); i++) begin
      if (slot_valid_q[i] && (slot_addr_q[i] == in_addr_i)) begin
        hit     = 1'b1;
        hit_idx = IdxWidth'(i);
      end
    end
  end

  // Lowest free index wins, so scan downwards and let the last match stick.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxWidth'(i);
      end
    end
  end

  assign hit_head    = slot_head_q[hit_idx];
  assign hit_tail    = slot_tail_q[hit_idx];
  assign is_head     = hit && (in_meta_i[MetaWidth-1:MetaIdWidth] == hit_head[MetaWidth-1:MetaIdWidth]);
  assign last_waiter = (hit_head[MetaWidth-1:MetaIdWidth] == hit_tail[MetaWidth-1:MetaIdWidth]);

  always_comb begin
    action = ActPass;
    if ((in_amo_i == AmoLrWait) && !in_lrwait_i) begin
      if (hit)           action = ActLrHit;
      else if (free_any) action = ActLrAlloc;
      else               action = ActLrFull;
    end else if (in_amo_i == AmoLrWait) begin
      action = hit ? ActWakeHit : ActWakeDrop;
    end else if (in_amo_i == AmoScWait) begin
      action = is_head ? ActScFwd : ActScFail;
    end
  end

  always_comb begin
    req_ready_raw = 1'b0;
    fwd           = 1'b0;
    fwd_wdata     = in_wdata_i;
    fwd_meta      = in_meta_i;
    inj_set       = 1'b0;
    inj_data_d    = '0;
    inj_meta_d    = in_meta_i;
    inj_error_d   = 1'b0;
    inj_lrwait_d  = 1'b0;
    case (action)
      ActPass, ActLrAlloc, ActScFwd: begin
        fwd           = 1'b1;
        req_ready_raw = bank_req_ready_i;
      end
      ActLrHit: begin
        req_ready_raw = 1'b1;
        inj_set       = 1'b1;
        inj_data_d    = DataWidth'(in_meta_i);
        inj_meta_d    = hit_tail;
        inj_lrwait_d  = 1'b1;
      end
      ActLrFull: begin
`ifdef LRWAIT_TABLE_FULL_STALL_EN
        req_ready_raw = 1'b0;
`else
        req_ready_raw = 1'b1;
        inj_set       = 1'b1;
        inj_error_d   = 1'b1;
`endif
      end
      ActWakeHit: begin
        // The read is re-issued on behalf of the successor so it lands there.
        fwd           = 1'b1;
        fwd_wdata     = '0;
        fwd_meta      = in_wdata_i[MetaWidth-1:0];
        req_ready_raw = bank_req_ready_i;
      end
      ActWakeDrop: begin
        req_ready_raw = 1'b1;
      end
      ActScFail: begin
        req_ready_raw = 1'b1;
        inj_set       = 1'b1;
        inj_data_d    = DataWidth'(1);
      end
      default: begin
        req_ready_raw = 1'b0;
      end
    endcase
  end

  assign req_act          = rst_ni && in_valid_i && !inj_valid_q;
  assign accept           = req_act && req_ready_raw;
  assign in_ready_o       = rst_ni && !inj_valid_q && req_ready_raw;
  assign bank_req_valid_o = req_act && fwd;
  assign bank_addr_o      = rst_ni ? in_addr_i : '0;
  assign bank_amo_o       = rst_ni ? in_amo_i : '0;
  assign bank_wdata_o     = rst_ni ? fwd_wdata : '0;
  assign bank_meta_o      = rst_ni ? fwd_meta : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_valid_q <= '0;
      for (int i = 0; i < int'(NumSlots); i++) begin
        slot_addr_q[i] <= '0;
        slot_head_q[i] <= '0;
        slot_tail_q[i] <= '0;
      end
    end else if (accept) begin
      case (action)
        ActLrHit: slot_tail_q[hit_idx] <= in_meta_i;
        ActLrAlloc: begin
          slot_valid_q[free_idx] <= 1'b1;
          slot_addr_q[free_idx]  <= in_addr_i;
          slot_head_q[free_idx]  <= in_meta_i;
          slot_tail_q[free_idx]  <= in_meta_i;
        end
        ActWakeHit: slot_head_q[hit_idx] <= in_wdata_i[MetaWidth-1:0];
        ActScFwd: begin
          if (last_waiter) slot_valid_q[hit_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Injection is blocked while pending, so set and clear never collide.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inj_valid_q  <= 1'b0;
      inj_data_q   <= '0;
      inj_meta_q   <= '0;
      inj_error_q  <= 1'b0;
      inj_lrwait_q <= 1'b0;
    end else if (accept && inj_set) begin
      inj_valid_q  <= 1'b1;
      inj_data_q   <= inj_data_d;
      inj_meta_q   <= inj_meta_d;
      inj_error_q  <= inj_error_d;
      inj_lrwait_q <= inj_lrwait_d;
    end else if (inj_valid_q && resp_ready_i && !bank_resp_valid_i) begin
      inj_valid_q  <= 1'b0;
    end
  end

  // Bank responses always win the response port.
  assign bank_resp_ready_o = rst_ni && resp_ready_i;
  assign resp_valid_o      = rst_ni && (bank_resp_valid_i || inj_valid_q);

  always_comb begin
    resp_data_o   = '0;
    resp_meta_o   = '0;
    resp_error_o  = 1'b0;
    resp_lrwait_o = 1'b0;
    if (rst_ni) begin
      if (bank_resp_valid_i) begin
        resp_data_o = bank_resp_data_i;
        resp_meta_o = bank_resp_meta_i;
      end else if (inj_valid_q) begin
        resp_data_o   = inj_data_q;
        resp_meta_o   = inj_meta_q;
        resp_error_o  = inj_error_q;
        resp_lrwait_o = inj_lrwait_q;
      end
    end
  end

endmodule

// File: tb/tb_lrwait_queue_table.sv
// Bench for lrwait_queue_table: directed scenarios plus random traffic, checked by
// a rule-level table model and a scoreboard fed by a simple bank model.
`timescale 1ns/1ps
module tb_lrwait_queue_table;

  localparam int NS  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = 16;
  localparam int MIW = 3;
  localparam int BRW = AW + 4 + DW + MW;
  localparam int RW  = DW + MW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [AW-1:0] in_addr_i = '0;
  logic [3:0]    in_amo_i = '0;
  logic [DW-1:0] in_wdata_i = '0;
  logic [MW-1:0] in_meta_i = '0;
  logic          in_lrwait_i = 1'b0;
  logic          bank_req_valid_o;
  logic          bank_req_ready_i = 1'b1;
  logic [AW-1:0] bank_addr_o;
  logic [3:0]    bank_amo_o;
  logic [DW-1:0] bank_wdata_o;
  logic [MW-1:0] bank_meta_o;
  logic          bank_resp_valid_i = 1'b0;
  logic          bank_resp_ready_o;
  logic [DW-1:0] bank_resp_data_i = '0;
  logic [MW-1:0] bank_resp_meta_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b1;
  logic [DW-1:0] resp_data_o;
  logic [MW-1:0] resp_meta_o;
  logic          resp_error_o;
  logic          resp_lrwait_o;

  lrwait_queue_table #(
    .NumSlots(NS), .AddrWidth(AW), .DataWidth(DW), .MetaWidth(MW), .MetaIdWidth(MIW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
    .in_amo_i(in_amo_i), .in_wdata_i(in_wdata_i), .in_meta_i(in_meta_i),
    .in_lrwait_i(in_lrwait_i),
    .bank_req_valid_o(bank_req_valid_o), .bank_req_ready_i(bank_req_ready_i),
    .bank_addr_o(bank_addr_o), .bank_amo_o(bank_amo_o), .bank_wdata_o(bank_wdata_o),
    .bank_meta_o(bank_meta_o),
    .bank_resp_valid_i(bank_resp_valid_i), .bank_resp_ready_o(bank_resp_ready_o),
    .bank_resp_data_i(bank_resp_data_i), .bank_resp_meta_i(bank_resp_meta_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_meta_o(resp_meta_o),
    .resp_error_o(resp_error_o), .resp_lrwait_o(resp_lrwait_o)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [BRW-1:0]   exp_bank_q[$];
  logic [RW-1:0]    exp_q[$];
  logic [DW+MW-1:0] bank_pend_q[$];

  logic          m_v [NS];
  logic [AW-1:0] m_a [NS];
  logic [MW-1:0] m_h [NS];
  logic [MW-1:0] m_t [NS];

  bit rnd_ready   = 1'b0;
  bit bank_hold   = 1'b0;
  bit resp_rdy_set = 1'b1;
  logic bresp_fire;
  logic [BRW-1:0] mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int find_slot(input logic [AW-1:0] a);
    find_slot = -1;
    for (int i = 0; i < NS; i++) if (m_v[i] && m_a[i] == a) find_slot = i;
  endfunction

  function automatic logic [MW-MIW-1:0] core_of(input logic [MW-1:0] m);
    return m[MW-1:MIW];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_v[i] = 1'b0; m_a[i] = '0; m_h[i] = '0; m_t[i] = '0;
    end
  endtask

  // Queue rules: what each request does to the table and what it should emit.
  task automatic model_apply(input logic [AW-1:0] a, input logic [3:0] amo,
                             input logic [DW-1:0] wd, input logic [MW-1:0] m, input logic lw);
    int h;
    int f;
    h = find_slot(a);
    f = -1;
    for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) f = i;
    if (amo == 4'hC && !lw) begin
      if (h >= 0) begin
        exp_q.push_back({DW'(m), m_t[h], 1'b0, 1'b1});
        m_t[h] = m;
      end else if (f >= 0) begin
        m_v[f] = 1'b1; m_a[f] = a; m_h[f] = m; m_t[f] = m;
        exp_bank_q.push_back({a, amo, wd, m});
      end else begin
        exp_q.push_back({DW'(0), m, 1'b1, 1'b0});
      end
    end else if (amo == 4'hC) begin
      if (h >= 0) begin
        m_h[h] = wd[MW-1:0];
        exp_bank_q.push_back({a, amo, DW'(0), m_h[h]});
      end
    end else if (amo == 4'hD) begin
      if (h >= 0 && core_of(m) == core_of(m_h[h])) begin
        exp_bank_q.push_back({a, amo, wd, m});
        if (core_of(m_h[h]) == core_of(m_t[h])) m_v[h] = 1'b0;
      end else begin
        exp_q.push_back({DW'(1), m, 1'b0, 1'b0});
      end
    end else begin
      exp_bank_q.push_back({a, amo, wd, m});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [AW-1:0] a, input logic [3:0] amo,
                       input logic [DW-1:0] wd, input logic [MW-1:0] m, input logic lw);
    in_addr_i = a; in_amo_i = amo; in_wdata_i = wd; in_meta_i = m; in_lrwait_i = lw;
    in_valid_i = 1'b1;
  endtask

  task automatic wait_accept();
    bit acc;
    acc = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (in_ready_o) begin acc = 1'b1; break; end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready_o=0 for 300 cycles addr=%0h amo=%0h, required 1", in_addr_i, in_amo_i);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [3:0] amo,
                      input logic [DW-1:0] wd, input logic [MW-1:0] m, input logic lw);
    model_apply(a, amo, wd, m, lw);
    drive(a, amo, wd, m, lw);
    wait_accept();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_bank_q.size() == 0 && bank_pend_q.size() == 0 && !resp_valid_o) begin
        done = 1'b1; break;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending inj=%0d bank=%0d pend=%0d, required 0", exp_q.size(), exp_bank_q.size(), bank_pend_q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- bank model and ready generation ----------------
  always @(posedge clk) begin
    bresp_fire = bank_resp_valid_i && bank_resp_ready_o;
    #1;
    if (bresp_fire && bank_pend_q.size() > 0) void'(bank_pend_q.pop_front());
    if (!rst_ni || bank_hold || bank_pend_q.size() == 0) bank_resp_valid_i = 1'b0;
    else if (bank_resp_valid_i && !bresp_fire) bank_resp_valid_i = 1'b1;
    else bank_resp_valid_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    {bank_resp_data_i, bank_resp_meta_i} = (bank_pend_q.size() > 0) ? bank_pend_q[0] : '0;
    bank_req_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    resp_ready_i     = rnd_ready ? ($urandom_range(0, 3) != 0) : resp_rdy_set;
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_ni) begin
      if (bank_req_valid_o && bank_req_ready_i) begin
        if (exp_bank_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bank_req_unexpected: got addr=%0h amo=%0h meta=%0h, required no request", bank_addr_o, bank_amo_o, bank_meta_o);
        end else begin
          mon_e = exp_bank_q.pop_front();
          chk("bank_req", {bank_addr_o, bank_amo_o, bank_wdata_o, bank_meta_o}, mon_e);
          bank_pend_q.push_back({mon_e[BRW-1 -: AW] ^ 32'h00A5_0000, mon_e[MW-1:0]});
        end
      end
      if (resp_valid_o && resp_ready_i) begin
        if (bank_resp_valid_i) begin
          chk("resp_bank", {resp_data_o, resp_meta_o, resp_error_o, resp_lrwait_o},
              {bank_resp_data_i, bank_resp_meta_i, 2'b00});
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got data=%0h meta=%0h err=%0b lrw=%0b, required no response", resp_data_o, resp_meta_o, resp_error_o, resp_lrwait_o);
        end else begin
          chk("resp_inj", {resp_data_o, resp_meta_o, resp_error_o, resp_lrwait_o}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [DW-1:0] wd;
    int op;
    int h;

    model_clear();
    drive(32'h100, 4'h1, 32'h1234, 16'h0010, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_bank_req_valid", bank_req_valid_o, 1'b0);
    chk("rst_bank_resp_ready", bank_resp_ready_o, 1'b0);
    chk("rst_resp_flags", {resp_valid_o, resp_error_o, resp_lrwait_o}, 3'b000);
    chk("rst_data_zero", {bank_addr_o, bank_wdata_o, bank_meta_o, resp_data_o}, '0);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    rst_ni = 1'b1;

    // Queue formation, hand-over and release on one address.
    send(32'h100, 4'hC, 32'h0, 16'h0010, 1'b0);
    drain();
    send(32'h100, 4'hC, 32'h0, 16'h0028, 1'b0);
    @(negedge clk);
    chk("succ_update_next_cycle", {resp_valid_o, resp_lrwait_o, resp_meta_o, resp_data_o},
        {1'b1, 1'b1, 16'h0010, 32'h28});
    drain();
    send(32'h100, 4'hD, 32'h7, 16'h0011, 1'b0);
    send(32'h100, 4'hC, 32'h28, 16'h0011, 1'b1);
    send(32'h100, 4'hD, 32'h9, 16'h0029, 1'b0);
    send(32'h100, 4'hD, 32'h9, 16'h0029, 1'b0);
    send(32'h200, 4'hD, 32'h3, 16'h0040, 1'b0);
    send(32'h300, 4'hC, 32'h55, 16'h0048, 1'b1);
    drain();

    // Fill the table, overflow, free one slot, retry.
    for (int i = 1; i <= 4; i++) send(AW'(i) << 12, 4'hC, 32'h0, MW'(16'h0100 + 8 * i), 1'b0);
    send(32'h5000, 4'hC, 32'h0, 16'h0130, 1'b0);
    send(32'h2000, 4'hD, 32'h1, 16'h0110, 1'b0);
    send(32'h5000, 4'hC, 32'h0, 16'h0130, 1'b0);
    send(32'h1000, 4'hD, 32'h1, 16'h0108, 1'b0);
    send(32'h3000, 4'hD, 32'h1, 16'h0118, 1'b0);
    send(32'h4000, 4'hD, 32'h1, 16'h0120, 1'b0);
    send(32'h5000, 4'hD, 32'h1, 16'h0130, 1'b0);
    drain();

    // Bank response and pending SuccUpdate competing for the response port.
    bank_hold = 1'b1;
    send(32'h700, 4'hC, 32'h0, 16'h0050, 1'b0);
    resp_rdy_set = 1'b0;
    send(32'h700, 4'hC, 32'h0, 16'h0058, 1'b0);
    bank_hold = 1'b0;
    model_apply(32'h800, 4'h2, 32'hABCD, 16'h0060, 1'b0);
    drive(32'h800, 4'h2, 32'hABCD, 16'h0060, 1'b0);
    @(negedge clk);
    chk("in_ready_blocked_by_inj", in_ready_o, 1'b0);
    @(negedge clk);
    chk("merge_bank_first", {resp_valid_o, resp_lrwait_o, resp_meta_o}, {1'b1, 1'b0, 16'h0050});
    chk("in_ready_still_blocked", in_ready_o, 1'b0);
    resp_rdy_set = 1'b1;
    wait_accept();
    send(32'h700, 4'hD, 32'h0, 16'h0051, 1'b0);
    send(32'h700, 4'hC, 32'h58, 16'h0051, 1'b1);
    send(32'h700, 4'hD, 32'h0, 16'h005C, 1'b0);
    drain();

    // Random traffic over a small address set.
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      a  = AW'(32'h100 * $urandom_range(1, 6));
      m  = MW'(($urandom_range(0, 7) << MIW) | $urandom_range(0, 7));
      wd = $urandom;
      op = $urandom_range(0, 9);
      h  = find_slot(a);
      if (op <= 3) begin
        send(a, 4'hC, wd, m, 1'b0);
      end else if (op <= 5) begin
        if (h >= 0 && $urandom_range(0, 3) != 0) m = {m_h[h][MW-1:MIW], MIW'($urandom)};
        send(a, 4'hD, wd, m, 1'b0);
      end else if (op <= 7) begin
        if (h >= 0 && $urandom_range(0, 1) == 1) wd[MW-1:0] = m_t[h];
        send(a, 4'hC, wd, m, 1'b1);
      end else begin
        send(a, 4'($urandom_range(0, 11)), wd, m, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();

    // Reset while a queue exists and an injection is pending.
    rnd_ready = 1'b0;
    send(32'h900, 4'hC, 32'h0, 16'h0070, 1'b0);
    drain();
    resp_rdy_set = 1'b0;
    send(32'h900, 4'hC, 32'h0, 16'h0078, 1'b0);
    rst_ni = 1'b0;
    exp_q.delete();
    exp_bank_q.delete();
    bank_pend_q.delete();
    model_clear();
    @(negedge clk);
    chk("midrst_outputs", {resp_valid_o, in_ready_o, bank_req_valid_o, resp_lrwait_o}, 4'b0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    resp_rdy_set = 1'b1;
    @(negedge clk);
    chk("no_inj_after_reset", resp_valid_o, 1'b0);
    @(posedge clk); #1;
    send(32'h900, 4'hC, 32'h0, 16'h0080, 1'b0);
    drain();

    chk("end_exp_inj_empty", exp_q.size(), 0);
    chk("end_exp_bank_empty", exp_bank_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
